// File: rtl/fdsynch_vec_if.sv
// Load/data/handshake bundle for the multi-channel synchronised loader.
interface fdsynch_vec_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS-1:0]       ld;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*WIDTH-1:0] qn;
  logic [CHANNELS-1:0]       ack;
  logic [CHANNELS-1:0]       upd;
  logic                      any_upd;

  modport master (output ld, d, input q, qn, ack, upd, any_upd);
  modport slave  (input ld, d, output q, qn, ack, upd, any_upd);
endinterface

// File: rtl/fdsynch_vec.sv
// Per-channel ld synchroniser that loads d into q on a level or toggle request,
// advancing only on sys_clk edges where the clk enable phase is high.
module fdsynch_vec #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 2,
  parameter int unsigned      STAGES   = 2,
  parameter int unsigned      MODE     = 0,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         clk,
  fdsynch_vec_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  logic [CHANNELS-1:0] load_vec_c;
  logic                any_upd_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic              ld_prev_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  qn_q;
    logic              upd_q;
    logic              load_c;

    // Level mode loads while the synchronised ld is high; toggle mode on any change.
    always_comb begin
      load_c = 1'b0;
      if (clk) begin
        if (MODE == 1) load_c = sync_q[LAST] ^ ld_prev_q;
        else           load_c = sync_q[LAST];
      end
    end

    always_ff @(posedge sys_clk) begin
      if (reset) begin
        sync_q    <= '0;
        ld_prev_q <= 1'b0;
        q_q       <= INIT;
        qn_q      <= ~INIT;
        upd_q     <= 1'b0;
      end else begin
        upd_q <= load_c;
        if (clk) begin
          sync_q    <= {sync_q[STAGES-2:0], bus.ld[n]};
          ld_prev_q <= sync_q[LAST];
        end
        if (load_c) begin
          q_q  <= bus.d[n*WIDTH +: WIDTH];
          qn_q <= ~bus.d[n*WIDTH +: WIDTH];
        end
      end
    end

    assign bus.q[n*WIDTH +: WIDTH]  = q_q;
    assign bus.qn[n*WIDTH +: WIDTH] = qn_q;
    assign bus.ack[n]               = sync_q[LAST];
    assign bus.upd[n]               = upd_q;
    assign load_vec_c[n]            = load_c;
  end

  // Registered alongside upd so it pulses in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) any_upd_q <= 1'b0;
    else       any_upd_q <= |load_vec_c;
  end

  assign bus.any_upd = any_upd_q;

endmodule

// File: tb/tb_fdsynch_vec.sv
// Scoreboard bench: two configurations (level/2-stage/2x8 and toggle/3-stage/8x32)
// checked against a history-based model of qualifying-edge ld samples.
module tb_fdsynch_vec;

  logic sys_clk;
  logic reset;
  logic ce;

  fdsynch_vec_if #(.WIDTH(8),  .CHANNELS(2)) if0 ();
  fdsynch_vec_if #(.WIDTH(32), .CHANNELS(8)) if1 ();

  fdsynch_vec #(.WIDTH(8), .CHANNELS(2), .STAGES(2), .MODE(0), .INIT(8'h5A)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .clk(ce), .bus(if0)
  );
  fdsynch_vec #(.WIDTH(32), .CHANNELS(8), .STAGES(3), .MODE(1), .INIT(32'h0)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .clk(ce), .bus(if1)
  );

  typedef struct {
    int          u;
    int          n;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  bit          hist[2][8][$];
  logic [31:0] mq[2][8];
  bit          eack[2][8];
  int          cycle;
  bit          mon_en;
  int          checks;
  int          errors;

  logic         rst_v, ce_v;
  logic [1:0]   ld0_v;
  logic [15:0]  d0_v;
  logic [7:0]   ld1_v;
  logic [255:0] d1_v;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int nch(input int u);
    return (u == 0) ? 2 : 8;
  endfunction
  function automatic int st(input int u);
    return (u == 0) ? 2 : 3;
  endfunction
  function automatic bit toggle_mode(input int u);
    return u != 0;
  endfunction
  function automatic logic [31:0] init_val(input int u);
    return (u == 0) ? 32'h5A : 32'h0;
  endfunction
  function automatic logic [31:0] dword(input int u, input int n);
    return (u == 0) ? 32'(d0_v[n*8 +: 8]) : d1_v[n*32 +: 32];
  endfunction
  function automatic bit ldbit(input int u, input int n);
    return (u == 0) ? ld0_v[n] : ld1_v[n];
  endfunction
  function automatic logic [31:0] qword(input int u, input int n);
    return (u == 0) ? 32'(if0.q[n*8 +: 8]) : if1.q[n*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // ld seen on qualifying edge j drives the load decision STAGES qualifying edges later.
  task automatic model_edge();
    int  sz;
    bit  cur, prv, load;
    cycle++;
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < nch(u); n++) begin
        if (reset) begin
          hist[u][n].delete();
          for (int k = 0; k < st(u) + 1; k++) hist[u][n].push_back(1'b0);
          mq[u][n]   = init_val(u);
          eack[u][n] = 1'b0;
        end else if (ce) begin
          sz   = hist[u][n].size();
          cur  = hist[u][n][sz - st(u)];
          prv  = hist[u][n][sz - st(u) - 1];
          load = toggle_mode(u) ? (cur != prv) : cur;
          if (load) begin
            mq[u][n] = dword(u, n);
            exp_q.push_back('{u: u, n: n, cyc: cycle, val: dword(u, n)});
          end
          hist[u][n].push_back(ldbit(u, n));
          while (hist[u][n].size() > st(u) + 2) void'(hist[u][n].pop_front());
          eack[u][n] = hist[u][n][hist[u][n].size() - st(u)];
        end
      end
    end
    if (reset) mon_en = 1'b1;
  endtask

  task automatic monitor_check();
    logic [7:0]   mask[2];
    logic [15:0]  eq0, eqn0;
    logic [255:0] eq1, eqn1;
    logic [1:0]   ea0;
    logic [7:0]   ea1;
    exp_t         e;
    mask[0] = '0;
    mask[1] = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      e = exp_q.pop_front();
      if (e.cyc != cycle) check("stale_load", 256'(e.cyc), 256'(cycle));
      else begin
        mask[e.u][e.n] = 1'b1;
        check("load_val", 256'(qword(e.u, e.n)), 256'(e.val));
      end
    end
    for (int n = 0; n < 2; n++) begin
      eq0[n*8 +: 8] = mq[0][n][7:0];
      ea0[n]        = eack[0][n];
    end
    for (int n = 0; n < 8; n++) begin
      eq1[n*32 +: 32] = mq[1][n];
      ea1[n]          = eack[1][n];
    end
    eqn0 = ~eq0;
    eqn1 = ~eq1;
    check("upd0", 256'(if0.upd), 256'(mask[0][1:0]));
    check("upd1", 256'(if1.upd), 256'(mask[1]));
    check("any_upd0", 256'(if0.any_upd), 256'(|mask[0]));
    check("any_upd1", 256'(if1.any_upd), 256'(|mask[1]));
    check("q0", 256'(if0.q), 256'(eq0));
    check("q1", if1.q, eq1);
    check("qn0", 256'(if0.qn), 256'(eqn0));
    check("qn1", if1.qn, eqn1);
    check("ack0", 256'(if0.ack), 256'(ea0));
    check("ack1", 256'(if1.ack), 256'(ea1));
  endtask

  always @(negedge sys_clk) if (mon_en) monitor_check();

  task automatic step();
    @(negedge sys_clk);
    reset  = rst_v;
    ce     = ce_v;
    if0.ld = ld0_v;
    if0.d  = d0_v;
    if1.ld = ld1_v;
    if1.d  = d1_v;
    @(posedge sys_clk);
    model_edge();
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; mon_en = 1'b0;
    rst_v = 1'b1; ce_v = 1'b0;
    ld0_v = '0; d0_v = '0; ld1_v = '0; d1_v = '0;
    reset = 1'b1; ce = 1'b0;
    if0.ld = '0; if0.d = '0; if1.ld = '0; if1.d = '0;

    // Reset with the enable low and high.
    repeat (2) step();
    ce_v = 1'b1;
    step();
    rst_v = 1'b0;

    // Single-cycle level pulse on channel 0.
    d0_v = 16'h00A5; ld0_v = 2'b01; step();
    ld0_v = '0; repeat (6) step();

    // Request in flight killed by reset, then a normal load.
    ld0_v = 2'b01; d0_v = 16'h6666; step();
    ld0_v = '0; rst_v = 1'b1; step();
    rst_v = 1'b0; repeat (5) step();
    ld0_v = 2'b10; d0_v = 16'h7700; step();
    ld0_v = '0; repeat (5) step();

    // Two toggles on channel 1 of the toggle-mode instance.
    d1_v[63:32] = 32'h3C; ld1_v[1] = 1'b1; repeat (6) step();
    d1_v[63:32] = 32'hC3; ld1_v[1] = 1'b0; repeat (6) step();

    // All eight channels toggle together with distinct data.
    for (int n = 0; n < 8; n++) d1_v[n*32 +: 32] = 32'(32'h1111_1111 * (n + 1));
    ld1_v = ~ld1_v; repeat (6) step();

    // ld held high through reset.
    ld1_v = 8'hFF; ld0_v = 2'b11; rst_v = 1'b1; repeat (2) step();
    rst_v = 1'b0; repeat (8) step();
    ld0_v = '0; ld1_v = '0; repeat (6) step();

    // Enable high one cycle in four.
    ld0_v = 2'b01; d0_v = 16'h1234;
    for (int i = 0; i < 40; i++) begin
      ce_v = (i % 4 == 0);
      step();
    end
    ld0_v = '0;
    for (int i = 0; i < 20; i++) begin
      ce_v = (i % 4 == 0);
      step();
    end

    // Random ld, data, enable and occasional reset.
    for (int i = 0; i < 800; i++) begin
      rst_v = ($urandom_range(99) == 0);
      ce_v  = (i < 400) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      for (int n = 0; n < 2; n++) if ($urandom_range(5) == 0) ld0_v[n] = ~ld0_v[n];
      for (int n = 0; n < 8; n++) if ($urandom_range(5) == 0) ld1_v[n] = ~ld1_v[n];
      d0_v = 16'($urandom);
      for (int n = 0; n < 8; n++) d1_v[n*32 +: 32] = $urandom;
      step();
    end
    rst_v = 1'b0; ce_v = 1'b1; ld0_v = '0;
    repeat (8) step();

    @(negedge sys_clk);
    #1;
    check("drain", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
